// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOT     = 3'd0;
  localparam op_t OP_AND     = 3'd1;
  localparam op_t OP_NAND    = 3'd2;
  localparam op_t OP_OR      = 3'd3;
  localparam op_t OP_NOR     = 3'd4;
  localparam op_t OP_XOR     = 3'd5;
  localparam op_t OP_XNOR    = 3'd6;
  localparam op_t OP_ILLEGAL = 3'd7;

  // Width-agnostic: the top applies this per bit lane, so any WIDTH works.
  // Operand b is ignored for NOT; the illegal opcode forces the lane to 0.
  function automatic logic lu_bit(op_t op, logic a, logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_illegal(op_t op);
    return (op == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head output masked to zero when empty.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: pushes ignored while full, pops ignored while empty.
module sync_fifo #(
  parameter int WIDTH_DATA = 10,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH_DATA-1:0]     push_dat,
  input  logic                      pop,
  output logic [WIDTH_DATA-1:0]     pop_dat,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  // One extra MSB per pointer distinguishes full from empty when indices match.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so plain binary increment wraps the index naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer state; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; stale contents never reach the port because of the empty mask.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Modular pointer difference spans 0..DEPTH thanks to the wrap bit.
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: decodes opcode, queues {err, zero, result} in a FIFO.
// Latency: one cycle from input accept to result at the head of an empty queue.
// Backpressure: in_ready drops when the queue is full; head holds while out_ready is low.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [2:0]                    in_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_res,
  output logic                          out_zero,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] res_d;
  logic             err_d;
  logic             zero_d;
  logic [EW-1:0]    entry_d;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Result is purely combinational from the operands; it is only captured on accept.
  always_comb begin
    res_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_d[i] = lu_bit(in_op, in_a[i], in_b[i]);
    end
    err_d   = op_is_illegal(in_op);
    zero_d  = ~|res_d;
    entry_d = {err_d, zero_d, res_d};
  end

  // in_ready comes only from registered pointer state (plus reset), never from
  // in_valid or out_ready; holding it high during reset matches the post-reset value.
  assign in_ready  = rst || !full;
  assign push      = in_valid && in_ready && !rst;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .WIDTH_DATA (EW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (entry_d),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .count    (occupancy)
  );

  // Head is already zero-masked inside the FIFO when empty.
  assign out_err  = head[EW-1];
  assign out_zero = head[EW-2];
  assign out_res  = head[WIDTH-1:0];

endmodule
